safe_access_ctrl: RTL

- Sequencer/arbiter that shares one `safe` PIN-entry FSM between NUM_REQ requesters.
- Each requester submits a 16-bit PIN (4 hex digits). The controller arbitrates round-robin, then runs each attempt on the safe:
  - pulses the safe's reset,
  - serialises the digits onto din/din_valid,
  - samples unlocked,
  - returns a tagged result.
- Tracks consecutive failures per requester and enforces a lockout cooldown.
- Sits between the keypad/host front-ends and the safe instance.

---
 rtl/safe_ctrl_pkg.sv | 30 +++
 rtl/safe_rr_arbiter.sv | 40 ++++
 rtl/safe_access_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/safe_ctrl_pkg.sv
// Shared types and constants for the safe access controller.
package safe_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int PIN_W      = 16;
  localparam int DIGIT_W    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SRST   = 3'd1,
    DIGIT  = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Digit k of a PIN, digit 0 being the most significant nibble.
  function automatic logic [DIGIT_W-1:0] pin_digit(input logic [PIN_W-1:0] pin,
                                                   input logic [1:0]       k);
    logic [DIGIT_W-1:0] d;
    case (k)
      2'd0:    d = pin[15:12];
      2'd1:    d = pin[11:8];
      2'd2:    d = pin[7:4];
      2'd3:    d = pin[3:0];
      default: d = {DIGIT_W{1'b0}};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/safe_rr_arbiter.sv
// Masked round-robin arbiter: searches upward from ptr, wrapping, for the
// first request that is not masked. Purely combinational.
module safe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand_s;

  // Pick the first unmasked requester at or after ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_s    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = int'(ptr) + off;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_any && req[cand_s] && !mask[cand_s]) begin
        grant_any        = 1'b1;
        grant[cand_s]    = 1'b1;
        grant_idx        = IDX_W'(cand_s);
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/safe_access_ctrl.sv
// Shares one safe PIN-entry FSM between NUM_REQ requesters: round-robin
// grant, safe reset pulse, digit serialisation, unlock sampling, and
// per-requester failure counting with a lockout cooldown.
module safe_access_ctrl
  import safe_ctrl_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int SAFE_RST_CYCLES = 2,
  parameter int SETTLE_CYCLES   = 2,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PIN_W-1:0]     req_pin,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         rsp_unlocked,
  output logic                         rsp_lockout,
  output logic [NUM_REQ-1:0]           locked_out,
  output logic                         safe_reset,
  output logic [DIGIT_W-1:0]           safe_din,
  output logic                         safe_din_valid,
  input  logic                         safe_unlocked
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (SAFE_RST_CYCLES > SETTLE_CYCLES) ? SAFE_RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_W   = $clog2(LOCKOUT_CYCLES + 1);

  state_e             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [1:0]         dig_r, dig_nxt_s;
  logic [PIN_W-1:0]   pin_r;
  logic [IDX_W-1:0]   id_r, ptr_r;
  logic [FAIL_W-1:0]  fail_cnt_r [NUM_REQ];
  logic [FAIL_W-1:0]  fail_nxt_s [NUM_REQ];
  logic [TMR_W-1:0]   timer_r    [NUM_REQ];
  logic [TMR_W-1:0]   timer_nxt_s[NUM_REQ];
  logic [NUM_REQ-1:0] locked_r;

  logic [NUM_REQ-1:0] arb_grant_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_any_s;
  logic               arb_en_s;
  logic               take_s;

  logic               safe_reset_nxt_s, din_valid_nxt_s;
  logic [DIGIT_W-1:0] din_nxt_s;
  logic               rsp_valid_nxt_s, rsp_unl_nxt_s, rsp_lock_nxt_s;
  logic [IDX_W-1:0]   rsp_id_nxt_s;

  safe_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .mask      (locked_r),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .grant_any (arb_any_s)
  );

  // Grants only exist in IDLE and never while reset is applied.
  always_comb begin
    arb_en_s = (state_r == IDLE) && reset_n;
    take_s   = arb_en_s && arb_any_s;
    if (arb_en_s) begin
      req_ready = arb_grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // FSM state and phase counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      dig_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dig_r   <= dig_nxt_s;
    end
  end

  // Next-state sequencing through reset pulse, digits, settle and response.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dig_nxt_s   = dig_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_nxt_s = SRST;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SRST: begin
        if (cnt_r == CNT_W'(SAFE_RST_CYCLES - 1)) begin
          state_nxt_s = DIGIT;
          cnt_nxt_s   = '0;
          dig_nxt_s   = 2'd0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DIGIT: begin
        if (dig_r == 2'(NUM_DIGITS - 1)) begin
          state_nxt_s = SETTLE;
          cnt_nxt_s   = '0;
        end else begin
          dig_nxt_s = dig_r + 2'd1;
        end
      end
      SETTLE: begin
        if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_nxt_s = RESP;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    safe_reset_nxt_s = (state_nxt_s == SRST);
    if (state_nxt_s == DIGIT) begin
      din_valid_nxt_s = 1'b1;
      din_nxt_s       = pin_digit(pin_r, dig_nxt_s);
    end else begin
      din_valid_nxt_s = 1'b0;
      din_nxt_s       = '0;
    end
    if ((state_r == SETTLE) && (state_nxt_s == RESP)) begin
      rsp_valid_nxt_s = 1'b1;
      rsp_id_nxt_s    = id_r;
      rsp_unl_nxt_s   = safe_unlocked;
      rsp_lock_nxt_s  = !safe_unlocked && (fail_cnt_r[id_r] == FAIL_W'(MAX_FAILS - 1));
    end else begin
      rsp_valid_nxt_s = 1'b0;
      rsp_id_nxt_s    = '0;
      rsp_unl_nxt_s   = 1'b0;
      rsp_lock_nxt_s  = 1'b0;
    end
  end

  // Registered outputs; safe held in reset while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      safe_reset     <= 1'b1;
      safe_din       <= '0;
      safe_din_valid <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_unlocked   <= 1'b0;
      rsp_lockout    <= 1'b0;
    end else begin
      safe_reset     <= safe_reset_nxt_s;
      safe_din       <= din_nxt_s;
      safe_din_valid <= din_valid_nxt_s;
      rsp_valid      <= rsp_valid_nxt_s;
      rsp_id         <= rsp_id_nxt_s;
      rsp_unlocked   <= rsp_unl_nxt_s;
      rsp_lockout    <= rsp_lock_nxt_s;
    end
  end

  // Latch the winner's PIN and id and advance the round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_r <= '0;
      id_r  <= '0;
      ptr_r <= '0;
    end else if (take_s) begin
      pin_r <= req_pin[arb_idx_s*PIN_W +: PIN_W];
      id_r  <= arb_idx_s;
      if (arb_idx_s == IDX_W'(NUM_REQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= arb_idx_s + IDX_W'(1);
      end
    end else begin
      pin_r <= pin_r;
    end
  end

  // Failure accounting in the RESP cycle and lockout timer countdown.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      fail_nxt_s[i] = fail_cnt_r[i];
      if (timer_r[i] != '0) begin
        timer_nxt_s[i] = timer_r[i] - TMR_W'(1);
      end else begin
        timer_nxt_s[i] = timer_r[i];
      end
      if ((state_r == RESP) && (id_r == IDX_W'(i))) begin
        if (rsp_unlocked) begin
          fail_nxt_s[i] = '0;
        end else if (rsp_lockout) begin
          fail_nxt_s[i]  = '0;
          timer_nxt_s[i] = TMR_W'(LOCKOUT_CYCLES);
        end else begin
          fail_nxt_s[i] = fail_cnt_r[i] + FAIL_W'(1);
        end
      end else begin
        fail_nxt_s[i] = fail_cnt_r[i];
      end
    end
  end

  // Per-requester failure counters, timers and lockout flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        fail_cnt_r[i] <= '0;
        timer_r[i]    <= '0;
      end
      locked_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        fail_cnt_r[i] <= fail_nxt_s[i];
        timer_r[i]    <= timer_nxt_s[i];
        locked_r[i]   <= (timer_nxt_s[i] != '0);
      end
    end
  end

  assign locked_out = locked_r;

endmodule
